// File: rtl/dso_capture_ctrl_if.sv
// Capture-controller bus: command/decimator/trigger inputs and RAM/status outputs.
// The auto_trig status signal exists only when CAP_AUTO_TRIG_EN is defined.
interface dso_capture_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              start_cap;
    logic              abort_cap;
    logic [ADDR_W-1:0] trig_pos;
    logic              smpl_en;
    logic              triggered;
    logic              done_ack;
    logic              trig_en;
    logic              armed;
    logic              set_capture_done;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] trace_end;
    logic              capture_done;
    logic              busy;
`ifdef CAP_AUTO_TRIG_EN
    logic              auto_trig;
`endif

    modport master (
        output start_cap, abort_cap, trig_pos, smpl_en, triggered, done_ack,
        input  trig_en, armed, set_capture_done, we, waddr, trace_end,
        input  capture_done, busy
`ifdef CAP_AUTO_TRIG_EN
        , input auto_trig
`endif
    );

    modport slave (
        input  start_cap, abort_cap, trig_pos, smpl_en, triggered, done_ack,
        output trig_en, armed, set_capture_done, we, waddr, trace_end,
        output capture_done, busy
`ifdef CAP_AUTO_TRIG_EN
        , output auto_trig
`endif
    );
endinterface

// File: rtl/dso_capture_ctrl.sv
// DSO capture sequencer: pre-trigger fill, arm, post-trigger count, done/abort handshake.
// Optional CAP_AUTO_TRIG_EN adds a forced trigger after AUTO_TO armed writes.
module dso_capture_ctrl #(
    parameter int ADDR_W = 9
`ifdef CAP_AUTO_TRIG_EN
    , parameter int AUTO_TO = 4096
`endif
) (
    input  logic              clk,
    input  logic              rst,
    dso_capture_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic [CW-1:0]     smpl_cnt_q, smpl_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] trace_end_q, trace_end_d;
    logic              cap_done_q, cap_done_d;
    logic              scd_q, scd_d;
    logic              trig_en_q, armed_q, busy_q;
    logic              busy_s, we_s, trig_fire;
    logic [CW-1:0]     fill_target;

    assign busy_s      = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
    assign we_s        = bus.smpl_en & busy_s;
    assign waddr_d     = we_s ? waddr_q + ADDR_W'(1) : waddr_q;
    // A 512-deep fill is needed when no post-trigger samples are requested.
    assign fill_target = DEPTH - {1'b0, pos_q};

`ifdef CAP_AUTO_TRIG_EN
    localparam int TW = $clog2(AUTO_TO + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          auto_q, auto_d;
    logic          auto_fire;

    assign auto_fire = we_s && (state_q == S_ARMED) && !bus.triggered &&
                       (to_cnt_q + TW'(1) == TW'(AUTO_TO));
    assign trig_fire = bus.triggered | auto_fire;
    assign bus.auto_trig = auto_q;
`else
    assign trig_fire = bus.triggered;
`endif

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        smpl_cnt_d  = smpl_cnt_q;
        post_cnt_d  = post_cnt_q;
        trace_end_d = trace_end_q;
        cap_done_d  = cap_done_q;
        scd_d       = 1'b0;
`ifdef CAP_AUTO_TRIG_EN
        to_cnt_d    = to_cnt_q;
        auto_d      = auto_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start_cap) begin
                    pos_d      = bus.trig_pos;
                    smpl_cnt_d = '0;
                    cap_done_d = 1'b0;
                    state_d    = S_FILL;
`ifdef CAP_AUTO_TRIG_EN
                    to_cnt_d   = '0;
                    auto_d     = 1'b0;
`endif
                end else if ((state_q == S_DONE) && bus.done_ack) begin
                    cap_done_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_FILL: begin
                if (we_s) begin
                    smpl_cnt_d = smpl_cnt_q + CW'(1);
                    if (smpl_cnt_d == fill_target) state_d = S_ARMED;
                end
            end
            S_ARMED: begin
`ifdef CAP_AUTO_TRIG_EN
                if (we_s) to_cnt_d = to_cnt_q + TW'(1);
                if (auto_fire) auto_d = 1'b1;
`endif
                if (trig_fire) begin
                    post_cnt_d = '0;
                    state_d    = (pos_q == '0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                if (we_s) begin
                    post_cnt_d = post_cnt_q + ADDR_W'(1);
                    if (post_cnt_d == pos_q) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort beats any transition computed above; the trigger flop still gets cleared.
        if (busy_s && bus.abort_cap) begin
            state_d = S_IDLE;
            scd_d   = 1'b1;
`ifdef CAP_AUTO_TRIG_EN
            auto_d  = auto_q;
`endif
        end else if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            scd_d       = 1'b1;
            cap_done_d  = 1'b1;
            trace_end_d = waddr_d - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            smpl_cnt_q  <= '0;
            post_cnt_q  <= '0;
            waddr_q     <= '0;
            trace_end_q <= '0;
            cap_done_q  <= 1'b0;
            scd_q       <= 1'b0;
            trig_en_q   <= 1'b0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            smpl_cnt_q  <= smpl_cnt_d;
            post_cnt_q  <= post_cnt_d;
            waddr_q     <= waddr_d;
            trace_end_q <= trace_end_d;
            cap_done_q  <= cap_done_d;
            scd_q       <= scd_d;
            trig_en_q   <= (state_d == S_FILL) || (state_d == S_ARMED) || (state_d == S_POST);
            armed_q     <= (state_d == S_ARMED) || (state_d == S_POST);
            busy_q      <= (state_d == S_FILL) || (state_d == S_ARMED) || (state_d == S_POST);
        end
    end

`ifdef CAP_AUTO_TRIG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            auto_q   <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            auto_q   <= auto_d;
        end
    end
`endif

    assign bus.trig_en          = trig_en_q;
    assign bus.armed            = armed_q;
    assign bus.set_capture_done = scd_q;
    assign bus.we               = we_s;
    assign bus.waddr            = waddr_q;
    assign bus.trace_end        = trace_end_q;
    assign bus.capture_done     = cap_done_q;
    assign bus.busy             = busy_q;
endmodule

// File: doc/dso_capture_ctrl.md
Name: dso_capture_ctrl

Overview:
- Capture sequencer for the DSO sample RAM.
- Arms the edge-trigger block once enough pre-trigger samples are stored, then counts post-trigger samples.
- Stops writes, pulses set_capture_done to clear the trigger SR-flop, and reports the final trace address to the command/readout logic.
- Sits between the command processor, the sample decimator, the trigger logic and the 512-entry capture RAM.

Parameters:
- ADDR_W, 9, RAM address width; depth = 2**ADDR_W (512).
- AUTO_TO, 4096, sample count before a forced trigger (used only with CAP_AUTO_TRIG_EN).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- start_cap  input  1  one-cycle pulse; begin a new capture.
- abort_cap  input  1  one-cycle pulse; abandon the capture in progress.
- trig_pos  input  ADDR_W  post-trigger sample count; sampled on start.
- smpl_en  input  1  sample strobe from the decimator; one RAM write per strobe while capturing.
- triggered  input  1  trigger SR-flop output from the trigger block.
- done_ack  input  1  host finished reading; clears capture_done.
- trig_en  output  1  enables the trigger block.
- armed  output  1  pre-trigger depth reached.
- set_capture_done  output  1  one-cycle clear pulse to the trigger SR-flop.
- we  output  1  RAM write enable.
- waddr  output  ADDR_W  RAM write address.
- trace_end  output  ADDR_W  address of the last sample written.
- capture_done  output  1  capture complete, RAM valid.
- busy  output  1  capture in progress (FILL, ARMED or POST).

Behaviour:
- Reset:
  - state IDLE; all outputs 0.
  - Internal pos_r, smpl_cnt and post_cnt are 0.
- Registered capture:
  - On start_cap in IDLE or DONE: pos_r <= trig_pos, smpl_cnt <= 0, capture_done <= 0, then go to FILL.
  - start_cap in FILL, ARMED or POST is ignored.
- Write path:
  - we = smpl_en & (state in FILL, ARMED, POST); purely combinational.
  - waddr increments by 1 (wraps 511->0) on every we; waddr is not reset on start, so it is a circular buffer.
- FILL:
  - trig_en = 1, armed = 0.
  - smpl_cnt increments on each we.
  - When a write brings smpl_cnt to 2**ADDR_W - pos_r, go to ARMED on the next cycle.
- ARMED:
  - trig_en = 1, armed = 1 (registered, asserted from the first ARMED cycle).
  - When triggered = 1: post_cnt <= 0, go to POST.
  - If pos_r == 0, go directly to DONE instead.
- POST:
  - trig_en = 1, armed = 1.
  - post_cnt increments on each we.
  - When a write makes post_cnt == pos_r, go to DONE the next cycle; that write is the last one.
- DONE entry:
  - set_capture_done pulses high for exactly 1 cycle.
  - trace_end <= address of the last write (waddr - 1 mod 2**ADDR_W).
  - capture_done <= 1; trig_en = 0, armed = 0, no writes.
- DONE:
  - capture_done holds until done_ack, then go to IDLE with capture_done cleared.
  - start_cap and done_ack in the same cycle: start wins, go to FILL.
- abort_cap:
  - In any busy state, go to IDLE the next cycle and pulse set_capture_done for 1 cycle.
  - capture_done stays 0; trace_end is unchanged.
  - abort has priority over every other transition in that cycle.
- smpl_en coinciding with a state change is written if the current state permits the write.
- Latency: triggered high to state POST is 1 clk; the final post write to capture_done high is 1 clk.
- Asynchronous rst mid-capture returns to IDLE immediately. No set_capture_done pulse is generated; the trigger block is reset by the same reset.

Optional Feature:
- Macro CAP_AUTO_TRIG_EN.
- When defined:
  - A timeout counter (width clog2(AUTO_TO+1)) counts we strobes in ARMED.
  - When it reaches AUTO_TO with triggered still 0, the block forces the ARMED->POST transition as if triggered.
  - Status output auto_trig (1 bit) is set on the forced transition and cleared on start_cap.
- When not defined:
  - No counter and no auto_trig port.
  - ARMED waits on triggered indefinitely.

Test Plan:
- trig_pos=100, smpl_en every cycle, triggered raised 20 cycles after armed:
  - armed rises after 412 writes.
  - Exactly 100 writes occur after the trigger.
  - set_capture_done pulses once; capture_done=1; trace_end = waddr-1.
- trig_pos=0, smpl_en continuous: armed after 512 writes; triggered -> DONE with 0 post writes; trace_end = last pre-trigger address.
- trig_pos=511, smpl_en every 4th cycle: armed after 1 write; 511 post writes; waddr wraps 511->0 with no gap.
- abort_cap during POST:
  - State is IDLE next cycle; set_capture_done pulses; capture_done=0; no further we.
  - start_cap then begins a fresh FILL.
- start_cap pulsed in FILL and ARMED is ignored (smpl_cnt continues). In DONE, start_cap together with done_ack enters FILL and clears capture_done.
- CAP_AUTO_TRIG_EN, AUTO_TO=16, triggered held 0: after 16 armed writes the block enters POST and auto_trig=1. Without the macro, the block stays ARMED for 10000 cycles.
